// File: rtl/load_align_unit_if.sv
// Request, data-memory and response signals of the load-align unit.
// The unit connects through the slave modport; the core/memory side uses master.
interface load_align_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [2:0]        req_op;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_fault;

    modport slave (
        input  req_valid, req_addr, req_op, mem_ready, mem_rdata,
        output req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
    );

    modport master (
        output req_valid, req_addr, req_op, mem_ready, mem_rdata,
        input  req_ready, mem_valid, mem_addr, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/load_align_unit.sv
// Load path: accepts one load, issues one or two aligned bus reads and
// returns the sign/zero-extended result (optionally splitting word-crossing loads).
module load_align_unit #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    load_align_if.slave bus
);
    localparam int          BYTES      = XLEN / 8;
    localparam int          OFFW       = $clog2(BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(32'(BYTES) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_op;
    logic [OFFW-1:0]   r_off;
    logic              r_two;
    logic [XLEN-1:0]   r_beat0;
    logic              r_mem_valid;
    logic [31:0]       r_mem_addr;
    logic              r_rsp_valid;
    logic              r_rsp_fault;
    logic [XLEN-1:0]   r_rsp_data;

    logic [4:0]        w_size;
    logic [4:0]        w_span;
    logic              w_two;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_req_fault;
    logic [XLEN-1:0]   w_beat_lo;
    logic [XLEN-1:0]   w_beat_hi;
    logic [XLEN-1:0]   w_aligned;
    logic [XLEN-1:0]   w_result;

    // Keep the low (8 << op[1:0]) bits; fill above with the sign bit for signed ops.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [2:0]      op);
        logic [XLEN-1:0] res;
        logic            sign;
        int              nbits;
        case (op[1:0])
            2'd0:    begin sign = raw[7];      nbits = 32'sd8;  end
            2'd1:    begin sign = raw[15];     nbits = 32'sd16; end
            2'd2:    begin sign = raw[31];     nbits = 32'sd32; end
            default: begin sign = raw[XLEN-1]; nbits = 32'sd64; end
        endcase
        sign = sign & ~op[2];
        for (int i = 32'sd0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? raw[i] : sign;
        end
        return res;
    endfunction

    // Request decode: size, alignment, legality and whether a second beat is needed.
    always_comb begin
        w_size = 5'd1 << bus.req_op[1:0];
        case (bus.req_op[1:0])
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = bus.req_addr[0];
            2'd2:    w_misaligned = |bus.req_addr[1:0];
            default: w_misaligned = |bus.req_addr[2:0];
        endcase
        w_illegal   = (bus.req_op == 3'd7) ||
                      ((XLEN == 32) && ((bus.req_op[1:0] == 2'd3) || (bus.req_op == 3'd6)));
        w_req_fault = w_illegal || (w_misaligned && !ALLOW_MISALIGNED);
        w_span      = 5'(bus.req_addr[OFFW-1:0]) + w_size;
        w_two       = (w_span > 5'(BYTES));
    end

    // Combine the beats: the second beat supplies the upper word of a crossing load.
    always_comb begin
        if (r_state == S_BEAT1) begin
            w_beat_lo = r_beat0;
            w_beat_hi = bus.mem_rdata;
        end else begin
            w_beat_lo = bus.mem_rdata;
            w_beat_hi = {XLEN{1'b0}};
        end
        w_aligned = XLEN'({w_beat_hi, w_beat_lo} >> {r_off, 3'b000});
        w_result  = extend_load(w_aligned, r_op);
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_req_fault) begin
                        w_next = S_RESP;
                    end else begin
                        w_next = S_BEAT0;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BEAT0: begin
                if (bus.mem_ready) begin
                    if (r_two) begin
                        w_next = S_BEAT1;
                    end else begin
                        w_next = S_RESP;
                    end
                end else begin
                    w_next = S_BEAT0;
                end
            end
            S_BEAT1: begin
                if (bus.mem_ready) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_BEAT1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture and bus address sequencing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op        <= 3'd0;
            r_off       <= {OFFW{1'b0}};
            r_two       <= 1'b0;
            r_beat0     <= {XLEN{1'b0}};
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
        end else begin
            r_mem_valid <= (w_next == S_BEAT0) || (w_next == S_BEAT1);
            if ((r_state == S_IDLE) && bus.req_valid) begin
                r_op  <= bus.req_op;
                r_off <= bus.req_addr[OFFW-1:0];
                r_two <= w_two;
                if (!w_req_fault) begin
                    r_mem_addr <= bus.req_addr & ALIGN_MASK;
                end
            end
            // The second beat address wraps naturally at the top of the 32-bit space.
            if ((r_state == S_BEAT0) && bus.mem_ready) begin
                r_beat0 <= bus.mem_rdata;
                if (r_two) begin
                    r_mem_addr <= r_mem_addr + 32'(BYTES);
                end
            end
        end
    end

    // Response strobe; data is held between responses and forced to 0 on a fault.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_data  <= {XLEN{1'b0}};
        end else begin
            r_rsp_valid <= (w_next == S_RESP);
            if (w_next == S_RESP) begin
                r_rsp_fault <= (r_state == S_IDLE);
                r_rsp_data  <= (r_state == S_IDLE) ? {XLEN{1'b0}} : w_result;
            end else begin
                r_rsp_fault <= 1'b0;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_fault = r_rsp_fault;
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three instances (32-bit split, 32-bit trapping, 64-bit),
// directed vector table, reset-abort sequence and randomized loads against a byte-level model.
module tb_load_align_unit;
    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    load_align_if #(.XLEN(32)) ifa ();
    load_align_if #(.XLEN(32)) ifb ();
    load_align_if #(.XLEN(64)) ifc ();

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa.slave));
    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb.slave));
    load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) dut_c (.clk(clk), .resetn(resetn), .bus(ifc.slave));

    logic        rqv  [3];
    logic [31:0] rqa  [3];
    logic [2:0]  rqo  [3];
    logic        mrdy [3];
    logic [63:0] mrd  [3];

    assign ifa.req_valid = rqv[0]; assign ifa.req_addr = rqa[0]; assign ifa.req_op = rqo[0];
    assign ifb.req_valid = rqv[1]; assign ifb.req_addr = rqa[1]; assign ifb.req_op = rqo[1];
    assign ifc.req_valid = rqv[2]; assign ifc.req_addr = rqa[2]; assign ifc.req_op = rqo[2];
    assign ifa.mem_ready = mrdy[0]; assign ifa.mem_rdata = mrd[0][31:0];
    assign ifb.mem_ready = mrdy[1]; assign ifb.mem_rdata = mrd[1][31:0];
    assign ifc.mem_ready = mrdy[2]; assign ifc.mem_rdata = mrd[2];

    wire        rr [3];
    wire        mv [3];
    wire [31:0] ma [3];
    wire        rv [3];
    wire [63:0] rd [3];
    wire        rf [3];

    assign rr[0] = ifa.req_ready; assign mv[0] = ifa.mem_valid; assign ma[0] = ifa.mem_addr;
    assign rv[0] = ifa.rsp_valid; assign rd[0] = {32'd0, ifa.rsp_data}; assign rf[0] = ifa.rsp_fault;
    assign rr[1] = ifb.req_ready; assign mv[1] = ifb.mem_valid; assign ma[1] = ifb.mem_addr;
    assign rv[1] = ifb.rsp_valid; assign rd[1] = {32'd0, ifb.rsp_data}; assign rf[1] = ifb.rsp_fault;
    assign rr[2] = ifc.req_ready; assign mv[2] = ifc.mem_valid; assign ma[2] = ifc.mem_addr;
    assign rv[2] = ifc.rsp_valid; assign rd[2] = ifc.rsp_data;          assign rf[2] = ifc.rsp_fault;

    // Memory contents, keyed by bus-aligned address; written only by the main process.
    logic [31:0] m32 [logic [31:0]];
    logic [63:0] m64 [logic [31:0]];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wt     [3];
    int          cnt    [3];
    int          mvcnt  [3];
    logic [31:0] hold   [3];
    logic [31:0] bq     [3][$];
    int          unstable = 0;

    function automatic logic [63:0] mem_peek(input bit w64, input logic [31:0] a);
        if (w64) return m64.exists(a) ? m64[a] : 64'd0;
        return m32.exists(a) ? {32'd0, m32[a]} : 64'd0;
    endfunction

    function automatic logic [63:0] mem_word(input bit w64, input logic [31:0] a);
        if (w64) begin
            if (!m64.exists(a)) m64[a] = {$urandom, $urandom};
            return m64[a];
        end
        if (!m32.exists(a)) m32[a] = $urandom;
        return {32'd0, m32[a]};
    endfunction

    // Memory responder: ready after wt[s] wait cycles, data looked up on the presented address.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (mv[s]) begin
                mvcnt[s]++;
                if (cnt[s] == 0) hold[s] = ma[s];
                else if (ma[s] != hold[s]) unstable++;
                if (cnt[s] >= wt[s]) begin
                    mrdy[s] = 1'b1;
                    mrd[s]  = mem_peek(s == 2, ma[s]);
                    bq[s].push_back(ma[s]);
                    cnt[s]  = 0;
                end else begin
                    mrdy[s] = 1'b0;
                    cnt[s]++;
                end
            end else begin
                mrdy[s] = 1'b0;
                cnt[s]  = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: assemble the loaded bytes one at a time from memory, then extend.
    function automatic void model(input int s, input logic [31:0] addr, input logic [2:0] op,
                                  output logic [63:0] data, output logic flt, output int nb,
                                  output logic [31:0] a0, output logic [31:0] a1);
        int          xlen  = (s == 2) ? 64 : 32;
        bit          allow = (s != 1);
        int          size  = 1 << op[1:0];
        int          b     = xlen / 8;
        int          off;
        logic [63:0] val;
        logic [31:0] ba;
        logic [7:0]  by;
        data = 64'd0; flt = 1'b0; nb = 0;
        a0 = addr & ~32'(b - 1);
        a1 = a0 + 32'(b);
        if (op == 3'd7 || (xlen == 32 && (size == 8 || op == 3'd6))) begin flt = 1'b1; return; end
        if ((int'(addr[2:0]) % size) != 0 && !allow) begin flt = 1'b1; return; end
        off = int'(addr[2:0]) % b;
        nb  = (off + size > b) ? 2 : 1;
        val = 64'd0;
        for (int k = 0; k < size; k++) begin
            ba  = addr + 32'(k);
            by  = 8'(mem_word(xlen == 64, ba & ~32'(b - 1)) >> (8 * (int'(ba[2:0]) % b)));
            val = val | (64'(by) << (8 * k));
        end
        if (!op[2] && size < 8 && val[8 * size - 1]) val = val | (~64'd0 << (8 * size));
        if (xlen == 32) val[63:32] = 32'd0;
        data = val;
    endfunction

    task automatic run_load(input int s, input logic [31:0] addr, input logic [2:0] op, input int w,
                            input bit junk, output logic [63:0] data, output logic flt,
                            output int lat, output bit got);
        wt[s] = w;
        got = 1'b0; lat = 0; data = 64'd0; flt = 1'b0;
        @(negedge clk);
        chk("req_ready idle", 64'(rr[s]), 64'd1);
        rqv[s] = 1'b1; rqa[s] = addr; rqo[s] = op;
        @(posedge clk); #1;
        if (junk) begin rqa[s] = $urandom; rqo[s] = 3'($urandom); end
        else rqv[s] = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (rv[s]) begin got = 1'b1; lat = c; data = rd[s]; flt = rf[s]; break; end
            @(posedge clk); #1;
        end
        rqv[s] = 1'b0;
        if (!got) begin
            chk("rsp timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk); #1;
            chk("rsp one-cycle", 64'(rv[s]), 64'd0);
            chk("ready after rsp", 64'(rr[s]), 64'd1);
            chk("rsp_data held", rd[s], data);
        end
    endtask

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [2:0]  op;
        int          w;
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    function automatic vec_t mkv(int sel, logic [31:0] addr, logic [2:0] op, int w,
                                 logic [63:0] w0, logic [63:0] w1, logic [63:0] ed, logic ef,
                                 int el, int eb, logic [31:0] a0, logic [31:0] a1);
        vec_t v;
        v.sel = sel; v.addr = addr; v.op = op; v.w = w; v.w0 = w0; v.w1 = w1;
        v.exp_data = ed; v.exp_fault = ef; v.exp_lat = el; v.exp_beats = eb; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    task automatic check_run(input string tag, input int s, input int w, input int q0, input int mv0,
                             input logic [63:0] d, input logic f, input int lat, input bit got,
                             input logic [63:0] ed, input logic ef, input int el, input int eb,
                             input logic [31:0] a0, input logic [31:0] a1);
        int nb;
        if (!got) return;
        nb = bq[s].size() - q0;
        chk({tag, " data"},  d, ed);
        chk({tag, " fault"}, 64'(f), 64'(ef));
        chk({tag, " lat"},   64'(lat), 64'(el));
        chk({tag, " beats"}, 64'(nb), 64'(eb));
        chk({tag, " mv cycles"}, 64'(mvcnt[s] - mv0), 64'(eb * (w + 1)));
        if (eb >= 1 && nb >= 1) chk({tag, " addr0"}, 64'(bq[s][q0]), 64'(a0));
        if (eb == 2 && nb >= 2) chk({tag, " addr1"}, 64'(bq[s][q0 + 1]), 64'(a1));
    endtask

    vec_t vecs[18];

    initial begin
        logic [63:0] d, ed;
        logic        f, ef;
        int          lat, nb, q0, mv0, w;
        bit          got;
        logic [31:0] a0, a1, addr;
        logic [2:0]  op;
        int          s;

        vecs[0]  = mkv(0, 32'h1000, 3'd2, 0, 64'hDEADBEEF, 64'h0, 64'hDEADBEEF, 1'b0, 2, 1, 32'h1000, 32'h1004);
        vecs[1]  = mkv(0, 32'h1003, 3'd0, 0, 64'h80FFFFFF, 64'h0, 64'hFFFFFF80, 1'b0, 2, 1, 32'h1000, 32'h1004);
        vecs[2]  = mkv(0, 32'h1003, 3'd4, 0, 64'h80FFFFFF, 64'h0, 64'h00000080, 1'b0, 2, 1, 32'h1000, 32'h1004);
        vecs[3]  = mkv(0, 32'h1001, 3'd1, 0, 64'h00ABCD00, 64'h0, 64'hFFFFABCD, 1'b0, 2, 1, 32'h1000, 32'h1004);
        vecs[4]  = mkv(0, 32'h1003, 3'd1, 0, 64'hAABBCCDD, 64'h11223344, 64'h000044AA, 1'b0, 3, 2, 32'h1000, 32'h1004);
        vecs[5]  = mkv(0, 32'h1003, 3'd1, 3, 64'hAABBCCDD, 64'h11223344, 64'h000044AA, 1'b0, 9, 2, 32'h1000, 32'h1004);
        vecs[6]  = mkv(1, 32'h1002, 3'd2, 0, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0, 32'h1000, 32'h1004);
        vecs[7]  = mkv(1, 32'h1000, 3'd7, 0, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0, 32'h1000, 32'h1004);
        vecs[8]  = mkv(0, 32'h1000, 3'd7, 0, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0, 32'h1000, 32'h1004);
        vecs[9]  = mkv(0, 32'h1000, 3'd3, 0, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0, 32'h1000, 32'h1004);
        vecs[10] = mkv(0, 32'h1000, 3'd6, 0, 64'h0, 64'h0, 64'h0, 1'b1, 1, 0, 32'h1000, 32'h1004);
        vecs[11] = mkv(0, 32'hFFFFFFFE, 3'd2, 0, 64'h12345678, 64'h9ABCDEF0, 64'hDEF01234, 1'b0, 3, 2, 32'hFFFFFFFC, 32'h0);
        vecs[12] = mkv(2, 32'h4, 3'd6, 0, 64'h80000000_00000000, 64'h0, 64'h00000000_80000000, 1'b0, 2, 1, 32'h0, 32'h8);
        vecs[13] = mkv(2, 32'h4, 3'd2, 0, 64'h80000000_00000000, 64'h0, 64'hFFFFFFFF_80000000, 1'b0, 2, 1, 32'h0, 32'h8);
        vecs[14] = mkv(2, 32'h6, 3'd3, 0, 64'h88776655_44332211, 64'hFFEEDDCC_BBAA9988, 64'hDDCCBBAA_99888877, 1'b0, 3, 2, 32'h0, 32'h8);
        vecs[15] = mkv(1, 32'h1002, 3'd1, 0, 64'h80011234, 64'h0, 64'hFFFF8001, 1'b0, 2, 1, 32'h1000, 32'h1004);
        vecs[16] = mkv(1, 32'h1001, 3'd1, 0, 64'h80011234, 64'h0, 64'h0, 1'b1, 1, 0, 32'h1000, 32'h1004);
        vecs[17] = mkv(0, 32'h1002, 3'd5, 1, 64'h80011234, 64'h0, 64'h00008001, 1'b0, 3, 1, 32'h1000, 32'h1004);

        for (int i = 0; i < 3; i++) begin
            rqv[i] = 1'b0; rqa[i] = 32'd0; rqo[i] = 3'd0; wt[i] = 0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d req_ready", i), 64'(rr[i]), 64'd1);
            chk($sformatf("rst%0d mem_valid", i), 64'(mv[i]), 64'd0);
            chk($sformatf("rst%0d mem_addr", i),  64'(ma[i]), 64'd0);
            chk($sformatf("rst%0d rsp_valid", i), 64'(rv[i]), 64'd0);
            chk($sformatf("rst%0d rsp_fault", i), 64'(rf[i]), 64'd0);
            chk($sformatf("rst%0d rsp_data", i),  rd[i], 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            s = vecs[i].sel;
            if (s == 2) begin m64[vecs[i].a0] = vecs[i].w0; m64[vecs[i].a1] = vecs[i].w1; end
            else begin m32[vecs[i].a0] = vecs[i].w0[31:0]; m32[vecs[i].a1] = vecs[i].w1[31:0]; end
            q0 = bq[s].size(); mv0 = mvcnt[s];
            run_load(s, vecs[i].addr, vecs[i].op, vecs[i].w, 1'b0, d, f, lat, got);
            check_run($sformatf("v%0d", i), s, vecs[i].w, q0, mv0, d, f, lat, got,
                      vecs[i].exp_data, vecs[i].exp_fault, vecs[i].exp_lat, vecs[i].exp_beats,
                      vecs[i].a0, vecs[i].a1);
        end

        // Reset while the first beat is still waiting for mem_ready.
        m32[32'h2000] = 32'hCAFEF00D;
        wt[0] = 20;
        @(negedge clk);
        rqv[0] = 1'b1; rqa[0] = 32'h2000; rqo[0] = 3'd2;
        @(posedge clk); #1;
        rqv[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort mem_valid before", 64'(mv[0]), 64'd1);
        chk("abort mem_addr before", 64'(ma[0]), 64'h2000);
        #2 resetn = 1'b0;
        #1;
        chk("abort mem_valid async", 64'(mv[0]), 64'd0);
        chk("abort req_ready", 64'(rr[0]), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort no rsp", 64'(rv[0]), 64'd0);
        end
        resetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort no rsp after", 64'(rv[0]), 64'd0);
        end
        q0 = bq[0].size(); mv0 = mvcnt[0];
        run_load(0, 32'h2000, 3'd2, 0, 1'b0, d, f, lat, got);
        check_run("post-reset", 0, 0, q0, mv0, d, f, lat, got,
                  64'hCAFEF00D, 1'b0, 2, 1, 32'h2000, 32'h2004);

        // Randomized loads; requests kept asserted with junk while busy.
        for (int i = 0; i < 150; i++) begin
            s    = $urandom_range(0, 2);
            op   = 3'($urandom_range(0, 7));
            w    = $urandom_range(0, 2);
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'h0000FFF0);
            addr = addr | 32'($urandom_range(0, 15));
            model(s, addr, op, ed, ef, nb, a0, a1);
            q0 = bq[s].size(); mv0 = mvcnt[s];
            run_load(s, addr, op, w, 1'b1, d, f, lat, got);
            check_run($sformatf("rnd%0d s%0d op%0d a%h", i, s, op, addr), s, w, q0, mv0,
                      d, f, lat, got, ed, ef, ef ? 1 : 1 + nb * (w + 1), nb, a0, a1);
        end

        chk("mem_addr stable while waiting", 64'(unstable), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
